// File: rtl/fsk_pkg.sv
// Shared FSK definitions: carrier divide defaults, edge-interval thresholds and the
// demodulator tracking state. The modulator side uses the same divide defaults.
package fsk_pkg;

    localparam int unsigned DIV_F1_DEF = 8;
    localparam int unsigned DIV_F2_DEF = 16;

    // Interval counter: 5 bits, saturating.
    localparam int unsigned INT_W = 5;
    localparam logic [INT_W-1:0] INT_MAX = '1;

    // Shortest interval still accepted as an F1 half-period.
    localparam int unsigned F1_MIN_I = 2;

    // Vote counters: 9 bits, saturating.
    localparam int unsigned VOTE_W = 9;
    localparam logic [VOTE_W-1:0] VOTE_MAX = '1;

    typedef enum logic {
        StHunt  = 1'b0,
        StTrack = 1'b1
    } fsk_state_e;

    // Upper F1 interval bound: midpoint between the two half-periods, minus one.
    function automatic int unsigned f1_max_i(int unsigned div_f1, int unsigned div_f2);
        return ((div_f1 / 2) + (div_f2 / 2)) / 2 - 1;
    endfunction

    // Upper F2 interval bound: 1.5 F2 half-periods.
    function automatic int unsigned f2_max_i(int unsigned div_f2);
        return (3 * (div_f2 / 2)) / 2;
    endfunction

    // Saturating single-step vote increment.
    function automatic logic [VOTE_W-1:0] vote_add(logic [VOTE_W-1:0] v, logic inc);
        return (inc && (v != VOTE_MAX)) ? v + VOTE_W'(1) : v;
    endfunction

endpackage

// File: rtl/fsk_edge_meter.sv
// Synchronizes the raw FSK input, detects transitions of either polarity, measures
// the interval since the previous transition and classifies it as F1 or F2.
module fsk_edge_meter
    import fsk_pkg::*;
#(
    parameter int unsigned DIV_F1 = DIV_F1_DEF,
    parameter int unsigned DIV_F2 = DIV_F2_DEF
) (
    input  logic in_clk,
    input  logic reset,
    input  logic fsk_i,
    output logic edge_o,
    output logic is_f1_o,
    output logic is_f2_o
);

    localparam logic [INT_W-1:0] F1Lo = INT_W'(F1_MIN_I);
    localparam logic [INT_W-1:0] F1Hi = INT_W'(f1_max_i(DIV_F1, DIV_F2));
    localparam logic [INT_W-1:0] F2Hi = INT_W'(f2_max_i(DIV_F2));

    // sync_q[0], sync_q[1]: metastability chain; sync_q[2]: delayed copy for edge detect.
    logic [2:0]       sync_q;
    logic [INT_W-1:0] int_cnt_q, int_cnt_d;
    logic [INT_W-1:0] interval;

    // Synchronizer chain and interval counter state.
    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            int_cnt_q <= INT_MAX;
        end else begin
            sync_q    <= {sync_q[1:0], fsk_i};
            int_cnt_q <= int_cnt_d;
        end
    end

    // Edge detect, saturating interval measure and F1/F2 classification.
    always_comb begin
        edge_o    = sync_q[1] ^ sync_q[2];
        interval  = (int_cnt_q == INT_MAX) ? INT_MAX : int_cnt_q + INT_W'(1);
        // Non-edge cycles just advance the (saturating) count; an edge restarts it.
        int_cnt_d = edge_o ? '0 : interval;
        is_f1_o   = edge_o && (interval >= F1Lo) && (interval <= F1Hi);
        is_f2_o   = edge_o && (interval > F1Hi) && (interval <= F2Hi);
    end

endmodule

// File: rtl/fsk_demod.sv
// Binary-FSK demodulator: counts per-edge F1/F2 votes over each symbol, decides one
// bit per symbol and tracks carrier presence with a HUNT/TRACK state machine.
module fsk_demod
    import fsk_pkg::*;
#(
    parameter int unsigned DIV_F1     = DIV_F1_DEF,
    parameter int unsigned DIV_F2     = DIV_F2_DEF,
    parameter int unsigned SYMBOL_LEN = 1024,
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned MIN_VOTES  = 64
) (
    input  logic in_clk,
    input  logic reset,
    input  logic fsk_in,
    input  logic sym_clr,
    output logic data_out,
    output logic data_valid,
    output logic locked,
    output logic carrier_lost
);

    localparam logic [CNT_W-1:0]  SymLast  = CNT_W'(SYMBOL_LEN - 1);
    localparam logic [VOTE_W:0]   MinVotes = (VOTE_W + 1)'(MIN_VOTES);

    logic edge_evt, is_f1, is_f2;

    fsk_edge_meter #(
        .DIV_F1 (DIV_F1),
        .DIV_F2 (DIV_F2)
    ) u_edge_meter (
        .in_clk  (in_clk),
        .reset   (reset),
        .fsk_i   (fsk_in),
        .edge_o  (edge_evt),
        .is_f1_o (is_f1),
        .is_f2_o (is_f2)
    );

    fsk_state_e        state_q;
    logic [CNT_W-1:0]  sym_cnt_q;
    logic [VOTE_W-1:0] f1_v_q, f2_v_q;
    logic              data_out_q, data_valid_q, locked_q;

    logic [VOTE_W-1:0] f1_tot, f2_tot;
    logic              carrier_ok;

    // Vote totals including the current cycle's vote, used for the symbol-end decision.
    always_comb begin
        f1_tot     = vote_add(f1_v_q, is_f1);
        f2_tot     = vote_add(f2_v_q, is_f2);
        carrier_ok = ({1'b0, f1_tot} + {1'b0, f2_tot}) >= MinVotes;
    end

    // Tracking FSM with symbol counter, vote counters and registered outputs.
    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StHunt;
            sym_cnt_q    <= '0;
            f1_v_q       <= '0;
            f2_v_q       <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                StHunt: begin
                    sym_cnt_q <= '0;
                    f1_v_q    <= '0;
                    f2_v_q    <= '0;
                    // The acquiring edge is symbol cycle 0 and already counts as a vote.
                    if (is_f1 || is_f2) begin
                        state_q   <= StTrack;
                        locked_q  <= 1'b1;
                        sym_cnt_q <= CNT_W'(1);
                        f1_v_q    <= VOTE_W'(is_f1);
                        f2_v_q    <= VOTE_W'(is_f2);
                    end
                end
                StTrack: begin
                    if (sym_clr) begin
                        // Realign: this cycle's vote and any decision are dropped.
                        sym_cnt_q <= '0;
                        f1_v_q    <= '0;
                        f2_v_q    <= '0;
                    end else if (sym_cnt_q == SymLast) begin
                        sym_cnt_q <= '0;
                        f1_v_q    <= '0;
                        f2_v_q    <= '0;
                        if (carrier_ok) begin
                            data_valid_q <= 1'b1;
                            // A tie keeps the previous bit.
                            if (f1_tot > f2_tot) begin
                                data_out_q <= 1'b1;
                            end else if (f2_tot > f1_tot) begin
                                data_out_q <= 1'b0;
                            end
                        end else begin
                            state_q  <= StHunt;
                            locked_q <= 1'b0;
                        end
                    end else begin
                        sym_cnt_q <= sym_cnt_q + CNT_W'(1);
                        f1_v_q    <= f1_tot;
                        f2_v_q    <= f2_tot;
                    end
                end
                default: begin
                    state_q  <= StHunt;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign locked       = locked_q;
    assign carrier_lost = ~locked_q;

endmodule

// File: tb/tb_fsk_demod.sv
// Directed and randomized bench for fsk_demod against a per-cycle reference model
// built from edge times, interval ranges and symbol start times.
module tb_fsk_demod;

    localparam int LEN  = 1024;
    localparam int MINV = 64;

    logic in_clk = 1'b0;
    logic reset  = 1'b0;
    logic fsk_in = 1'b0;
    logic sym_clr = 1'b0;
    logic data_out, data_valid, locked, carrier_lost;

    fsk_demod dut (
        .in_clk       (in_clk),
        .reset        (reset),
        .fsk_in       (fsk_in),
        .sym_clr      (sym_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .locked       (locked),
        .carrier_lost (carrier_lost)
    );

    always #5 in_clk = ~in_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int cyc = 0;          // posedge index
    bit h1, h2, h3;       // input sampled 1, 2, 3 posedges ago
    int last_edge;        // posedge of the previous input edge event
    bit m_lock;
    int sym_start;        // posedge that is cycle 0 of the current symbol
    int t1, t2;           // F1/F2 votes counted so far in this symbol
    bit e_dout, e_dv;

    bit cur = 1'b0;       // current driven level
    int dv_count = 0;
    bit bits_q[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        h1 = 0; h2 = 0; h3 = 0;
        last_edge = cyc - 1000;
        m_lock = 0; sym_start = 0; t1 = 0; t2 = 0;
        e_dout = 0; e_dv = 0;
    endtask

    // One posedge of the reference: f is the level sampled now, c is sym_clr.
    task automatic model(input bit f, input bit c);
        bit ev, v1, v2;
        int ival;
        cyc++;
        ev   = (h2 != h3);
        ival = cyc - last_edge;
        if (ival > 31) ival = 31;
        if (ev) last_edge = cyc;
        v1 = ev && ival >= 2 && ival <= 5;
        v2 = ev && ival >= 6 && ival <= 12;
        h3 = h2; h2 = h1; h1 = f;
        e_dv = 0;
        if (!m_lock) begin
            if (v1 || v2) begin
                m_lock = 1; sym_start = cyc; t1 = v1; t2 = v2;
            end
        end else if (c) begin
            sym_start = cyc + 1; t1 = 0; t2 = 0;
        end else begin
            t1 = (t1 + v1 > 511) ? 511 : t1 + v1;
            t2 = (t2 + v2 > 511) ? 511 : t2 + v2;
            if (cyc - sym_start == LEN - 1) begin
                if (t1 + t2 >= MINV) begin
                    e_dv = 1;
                    if (t1 > t2) e_dout = 1;
                    else if (t2 > t1) e_dout = 0;
                end else begin
                    m_lock = 0;
                end
                t1 = 0; t2 = 0; sym_start = cyc + 1;
            end
        end
    endtask

    task automatic step(input bit f, input bit c);
        @(negedge in_clk);
        fsk_in = f;
        sym_clr = c;
        @(posedge in_clk);
        model(f, c);
        #1;
        check("data_valid", data_valid, e_dv);
        check("data_out", data_out, e_dout);
        check("locked", locked, m_lock);
        check("carrier_lost", carrier_lost, !m_lock);
        if (data_valid === 1'b1) begin
            dv_count++;
            bits_q.push_back(data_out);
        end
    endtask

    // Square wave with the given half-period (0 = hold level) for n cycles.
    task automatic run(input int half, input int n);
        int ph = 0;
        for (int i = 0; i < n; i++) begin
            if (half != 0) begin
                ph++;
                if (ph == half) begin
                    cur = ~cur;
                    ph = 0;
                end
            end
            step(cur, 1'b0);
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(posedge in_clk);
        #2 reset = 1'b0;
        #1;
        check("rst_data_out", data_out, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_carrier_lost", carrier_lost, 1'b1);
        model_reset();
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("init_data_out", data_out, 1'b0);
        check("init_data_valid", data_valid, 1'b0);
        check("init_locked", locked, 1'b0);
        check("init_carrier_lost", carrier_lost, 1'b1);
        @(negedge in_clk);
        reset = 1'b1;

        // Steady F1 for three symbols
        dv_count = 0;
        run(4, 3 * LEN + 40);
        check_int("f1_strobes", dv_count, 3);
        check("f1_bit", data_out, 1'b1);

        // Steady F2
        run(8, 3 * LEN);
        check("f2_bit", data_out, 1'b0);

        // Realign, then alternate F1/F2 per symbol
        step(cur, 1'b1);
        bits_q.delete();
        for (int k = 0; k < 4; k++) run((k % 2 == 0) ? 4 : 8, LEN);
        run(4, 20);
        check_int("alt_strobes", bits_q.size(), 4);
        if (bits_q.size() == 4) begin
            for (int k = 0; k < 4; k++) check("alt_bit", bits_q[k], (k % 2) == 0);
        end

        // Carrier removed mid-TRACK, then F1 re-acquires
        run(4, LEN + 100);
        run(0, 2 * LEN + 50);
        check("lost_locked", locked, 1'b0);
        check("lost_carrier", carrier_lost, 1'b1);
        check("lost_hold", data_out, 1'b1);
        run(4, 40);
        check("reacq_locked", locked, 1'b1);

        // Randomized segments, including saturation (half=2) and occasional realign
        for (int s = 0; s < 12; s++) begin
            int half;
            half = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 14));
            if ($urandom_range(0, 3) == 0) step(cur, 1'b1);
            run(half, int'($urandom_range(100, 1500)));
        end

        // Half-period sweep, each from reset (mid-symbol reset included)
        do_reset();
        run(5, LEN + 100);
        check("h5_locked", locked, 1'b1);
        check("h5_bit", data_out, 1'b1);
        do_reset();
        run(6, LEN + 100);
        check("h6_locked", locked, 1'b1);
        check("h6_bit", data_out, 1'b0);
        do_reset();
        run(12, LEN + 100);
        check("h12_locked", locked, 1'b1);
        check("h12_bit", data_out, 1'b0);
        do_reset();
        run(13, 2 * LEN);
        check("h13_nolock", locked, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
